// File: rtl/ship_sprite_pkg.sv
// ----------------------------------------------------------------------------
// ship_sprite_pkg
//   Shared constants and sprite art for the command-ship renderer.
//   The renderer and the sprite ROM use the same geometry constants, so
//   address math (base(angle) + row) and column math (q[col]) agree.
//
//   Art is held as two master bitmaps: heading 0 (nose up) and heading 1
//   (nose up-right). Every other heading is one of these turned clockwise
//   in 90 deg steps. This makes headings 2/4/6 exact rotations of heading 0.
//   Row words use bit c = column c, where bit 0 is the leftmost column.
// ----------------------------------------------------------------------------
package ship_sprite_pkg;

    localparam int SPRITE_W    = 20;
    localparam int SPRITE_ROWS = 20;
    localparam int N_ANGLES    = 8;
    localparam int IMAGE_WORDS = SPRITE_ROWS * N_ANGLES;

    typedef enum logic [2:0] {
        HEAD_UP         = 3'd0,
        HEAD_UP_RIGHT   = 3'd1,
        HEAD_RIGHT      = 3'd2,
        HEAD_DOWN_RIGHT = 3'd3,
        HEAD_DOWN       = 3'd4,
        HEAD_DOWN_LEFT  = 3'd5,
        HEAD_LEFT       = 3'd6,
        HEAD_UP_LEFT    = 3'd7
    } heading_t;

    // First word of a heading's bitmap.
    function automatic int base(input int angle);
        return SPRITE_ROWS * angle;
    endfunction

    // Master bitmaps. diag=0 gives heading 0 (mirror-symmetric).
    // diag=1 gives heading 1 (45 deg clockwise).
    function automatic logic [SPRITE_W-1:0] masterRow(input logic diag, input int row);
        logic [SPRITE_W-1:0] w;
        w = '0;
        if (!diag) begin
            case (row)
                0:       w = 20'h00600;
                1, 2:    w = 20'h00F00;
                3, 5:    w = 20'h01F80;
                4:       w = 20'h01980;
                6, 7:    w = 20'h03FC0;
                8:       w = 20'h07FE0;
                9:       w = 20'h1FFF8;
                10, 13:  w = 20'h7FFFE;
                11, 12:  w = 20'hFFFFF;
                14, 17:  w = 20'h07FE0;
                15, 16:  w = 20'h03FC0;
                18:      w = 20'h0F0F0;
                19:      w = 20'h0E070;
                default: w = '0;
            endcase
        end else begin
            case (row)
                0:       w = 20'hC0000;
                1:       w = 20'hF0000;
                2:       w = 20'hF8000;
                3:       w = 20'h7C000;
                4:       w = 20'h3E000;
                5:       w = 20'h1F000;
                6:       w = 20'h0F800;
                7:       w = 20'h07FF0;
                8:       w = 20'h03FE0;
                9:       w = 20'h01FC0;
                10:      w = 20'h00FC0;
                11:      w = 20'h007C0;
                12:      w = 20'h003E0;
                13:      w = 20'h001F0;
                14:      w = 20'h000F8;
                15:      w = 20'h0007C;
                16:      w = 20'h0003E;
                17:      w = 20'h0001F;
                18:      w = 20'h0000F;
                19:      w = 20'h00003;
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    // ROM word at a flat address. Headings 2..7 are obtained by turning
    // the matching master clockwise (angle/2) quarter turns. Addresses past
    // the image return zero.
    function automatic logic [SPRITE_W-1:0] imageWord(input int addr);
        logic [SPRITE_W-1:0] word;
        logic [SPRITE_W-1:0] src;
        int angle;
        int row;
        int sr;
        int sc;
        word = '0;
        if (addr >= 0 && addr < IMAGE_WORDS) begin
            angle = addr / SPRITE_ROWS;
            row   = addr % SPRITE_ROWS;
            for (int c = 0; c < SPRITE_W; c++) begin
                case (angle / 2)
                    0:       begin sr = row;                sc = c;                  end
                    1:       begin sr = SPRITE_W - 1 - c;   sc = row;                end
                    2:       begin sr = SPRITE_ROWS - 1 - row; sc = SPRITE_W - 1 - c; end
                    default: begin sr = c;                  sc = SPRITE_ROWS - 1 - row; end
                endcase
                src     = masterRow(angle[0], sr);
                word[c] = src[sc];
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/ship_sprite.sv
// ----------------------------------------------------------------------------
// ship_sprite
//   Single-port synchronous sprite ROM: 8 ship headings x 20 rows of 20-bit
//   monochrome row words. The word for heading a, row r is at 20*a + r.
//   Addresses 160..255 read as zero.
//
//   Ports
//     address  in  ADDR_W  word address (20*angle + row), sampled every edge
//     clock    in  1       rising-edge memory clock
//     q        out WIDTH   registered row word, q[c] = pixel at column c
//     iRst     in  1       asynchronous active-low clear of q
// ----------------------------------------------------------------------------
module ship_sprite
    import ship_sprite_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter int ADDR_W   = 8,
    parameter int N_ANGLES = 8,
    parameter int ROWS     = 20
) (
    input  logic [ADDR_W-1:0] address,
    input  logic              clock,
    output logic [WIDTH-1:0]  q,
    input  logic              iRst
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Constant image: each word is fixed at elaboration, so the table
    // reduces to a ROM followed by the output register.
    logic [WIDTH-1:0] romImg [DEPTH];

    for (genvar a = 0; a < DEPTH; a++) begin : gRom
        localparam logic [WIDTH-1:0] WORD =
            (a < N_ANGLES * ROWS) ? WIDTH'(imageWord(a)) : '0;
        assign romImg[a] = WORD;
    end

    always_ff @(posedge clock or negedge iRst) begin
        if (!iRst) begin
            q <= '0;
        end else begin
            q <= romImg[address];
        end
    end

`ifdef SIM
    // Content self-check of the art at time zero.
    task automatic contentSelfCheck();
        logic [SPRITE_W-1:0] orWord;
        logic [SPRITE_W-1:0] w0;
        logic [SPRITE_W-1:0] w2;
        logic [SPRITE_W-1:0] w4;
        logic [SPRITE_W-1:0] wc;
        for (int a = 0; a < N_ANGLES; a++) begin
            orWord = '0;
            for (int r = 0; r < ROWS; r++) orWord |= imageWord(base(a) + r);
            if (orWord == '0) $error("ship_sprite: heading %0d is empty", a);
        end
        for (int r = 0; r < ROWS; r++) begin
            w0 = imageWord(base(0) + r);
            w2 = imageWord(base(2) + r);
            w4 = imageWord(base(4) + r);
            for (int c = 0; c < SPRITE_W; c++) begin
                wc = imageWord(base(0) + SPRITE_W - 1 - c);
                if (w0[c] != w0[SPRITE_W-1-c])
                    $error("ship_sprite: heading 0 row %0d not mirror-symmetric", r);
                if (w2[c] != wc[r])
                    $error("ship_sprite: heading 2 row %0d col %0d not a rotation", r, c);
            end
            if (w4 != imageWord(base(0) + ROWS - 1 - r))
                $error("ship_sprite: heading 4 row %0d not a vertical flip", r);
        end
    endtask

    initial contentSelfCheck();
`endif

endmodule

// File: tb/tb_ship_sprite.sv
// ----------------------------------------------------------------------------
// tb_ship_sprite
//   Self-checking bench for ship_sprite. The reference image is built from a
//   geometric description of the ship: half-widths and holes for the upright
//   ship, and column spans for the diagonal ship. Other headings come from
//   repeated quarter-turn rotation of a pixel grid.
// ----------------------------------------------------------------------------
module tb_ship_sprite;

    logic [7:0]  address;
    logic        clock = 1'b0;
    logic [19:0] q;
    logic        iRst;

    ship_sprite dut (
        .address (address),
        .clock   (clock),
        .q       (q),
        .iRst    (iRst)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Upright ship: row r spans columns 10-half..9+half.
    // A nonzero hole h clears columns 10-h..9+h.
    int half0 [20] = '{1,2,2,3,3,3,4,4,5,7,9,10,10,9,5,4,4,5,6,6};
    int hole0 [20] = '{0,0,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,2,3};
    // Diagonal ship: row r spans columns lo1..hi1.
    int lo1   [20] = '{18,16,15,14,13,12,11,4,5,6,6,6,5,4,3,2,1,0,0,0};
    int hi1   [20] = '{19,19,19,18,17,16,15,14,13,12,11,10,9,8,7,6,5,4,3,1};

    bit          grid   [8][20][20];
    logic [19:0] expRom [256];

    typedef struct {
        logic [7:0]  addr;
        logic [19:0] want;
        string       name;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic buildModel();
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < 20; c++) begin
                grid[0][r][c] = (c >= 10 - half0[r]) && (c <= 9 + half0[r]) &&
                                !((hole0[r] > 0) && (c >= 10 - hole0[r]) && (c <= 9 + hole0[r]));
                grid[1][r][c] = (c >= lo1[r]) && (c <= hi1[r]);
            end
        end
        // A clockwise quarter turn sends old row 19-c, column r to new row r, column c.
        for (int h = 2; h < 8; h++)
            for (int r = 0; r < 20; r++)
                for (int c = 0; c < 20; c++)
                    grid[h][r][c] = grid[h-2][19-c][r];
        for (int a = 0; a < 256; a++) expRom[a] = '0;
        for (int h = 0; h < 8; h++)
            for (int r = 0; r < 20; r++)
                for (int c = 0; c < 20; c++)
                    expRom[20*h + r][c] = grid[h][r][c];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] h0 [20];
        logic [19:0] mir;
        logic [19:0] orWord;
        logic [19:0] held;
        logic [7:0]  nextAddr;

        buildModel();
        vecs[0]  = '{8'd0,   20'h00600, "h0_row0"};
        vecs[1]  = '{8'd11,  20'hFFFFF, "h0_row11"};
        vecs[2]  = '{8'd19,  20'h0E070, "h0_row19"};
        vecs[3]  = '{8'd20,  20'hC0000, "h1_row0"};
        vecs[4]  = '{8'd39,  20'h00003, "h1_row19"};
        vecs[5]  = '{8'd40,  20'h00180, "h2_row0"};
        vecs[6]  = '{8'd49,  20'hF7FFC, "h2_row9"};
        vecs[7]  = '{8'd60,  20'h00007, "h3_row0"};
        vecs[8]  = '{8'd80,  20'h0E070, "h4_row0"};
        vecs[9]  = '{8'd91,  20'h07FE0, "h4_row11"};
        vecs[10] = '{8'd120, 20'h01800, "h6_row0"};
        vecs[11] = '{8'd160, 20'h00000, "blank_160"};
        vecs[12] = '{8'd200, 20'h00000, "blank_200"};
        vecs[13] = '{8'd255, 20'h00000, "blank_255"};

        // Reset held across three edges, then the first read.
        iRst    = 1'b1;
        address = 8'd0;
        #2 iRst = 1'b0;
        #1 check("reset_async", q, 20'h00000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_hold", q, 20'h00000);
        end
        iRst = 1'b1;
        step();
        check("first_read", q, expRom[0]);

        // Full sweep, one address per edge.
        for (int k = 0; k < 160; k++) begin
            address = 8'(k);
            step();
            check($sformatf("sweep_%0d", k), q, expRom[k]);
        end

        // Hand-derived table, including the blank region.
        for (int i = 0; i < 14; i++) begin
            address = vecs[i].addr;
            step();
            check(vecs[i].name, q, vecs[i].want);
            check({vecs[i].name, "_model"}, expRom[vecs[i].addr], vecs[i].want);
        end

        // Heading 0 symmetry and heading 4 as its vertical flip.
        for (int r = 0; r < 20; r++) begin
            address = 8'(r);
            step();
            h0[r] = q;
            for (int c = 0; c < 20; c++) mir[c] = q[19-c];
            check($sformatf("h0_mirror_%0d", r), mir, expRom[r]);
        end
        for (int r = 0; r < 20; r++) begin
            address = 8'(80 + r);
            step();
            check($sformatf("h4_flip_%0d", r), q, h0[19-r]);
        end

        // Reset asserted mid-stream between edges.
        address = 8'd45;
        step();
        check("h2_row5", q, expRom[45]);
        #2 iRst = 1'b0;
        #1 check("midreset_clear", q, 20'h00000);
        address = 8'd99;
        step();
        check("midreset_edge", q, 20'h00000);
        iRst = 1'b1;
        step();
        check("after_release", q, expRom[99]);

        // Every heading has at least one set pixel.
        for (int a = 0; a < 8; a++) begin
            orWord = '0;
            for (int r = 0; r < 20; r++) begin
                address = 8'(20*a + r);
                step();
                orWord |= q;
            end
            check($sformatf("nonempty_h%0d", a), 20'(orWord != 0), 20'd1);
        end

        // Renderer pixel path: edge columns.
        address = 8'd11;
        step();
        check("pix_col0_set",  20'(q[0]),  20'd1);
        check("pix_col19_set", 20'(q[19]), 20'd1);
        address = 8'd0;
        step();
        check("pix_col0_clr",  20'(q[0]),  20'd0);
        check("pix_col19_clr", 20'(q[19]), 20'd0);

        // Random addresses with glitches between edges and occasional resets.
        held = q;
        for (int i = 0; i < 300; i++) begin
            address = 8'($urandom_range(255, 0));
            #1 address = 8'($urandom_range(255, 0));
            #1 check("glitch_hold", q, held);
            nextAddr = 8'($urandom_range(255, 0));
            address  = nextAddr;
            if ($urandom_range(15, 0) == 0) begin
                iRst = 1'b0;
                #1 check("rand_reset", q, 20'h00000);
                iRst = 1'b1;
            end
            step();
            check("rand_read", q, expRom[nextAddr]);
            held = expRom[nextAddr];
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
